// File: rtl/alarm_beep_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_beep_ctrl
//
// Alarm ringing sequencer. After an alarm match (with the alarm armed), the
// buzzer is driven in bursts of BEEPS beeps (ON_TICKS on, OFF_TICKS off
// between beeps) followed by PAUSE_TICKS of silence. This repeats for BURSTS
// bursts, after which the sequence times out by itself. The user can stop the
// alarm or snooze it. Snoozing silences it for SNOOZE_TICKS, then ringing
// restarts with a fresh timeout window.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   tick         in   one-cycle time-base strobe (nominally 10 Hz)
//   alarm_en     in   alarm armed level
//   alarm_match  in   one-cycle strobe: current time equals alarm time
//   stop         in   one-cycle strobe: user dismiss
//   snooze       in   one-cycle strobe: user snooze
//   buzz         out  buzzer enable (ON phase)
//   active       out  ringing sequence in progress (ON/OFF/PAUSE)
//   snoozing     out  in snooze wait
//   timeout      out  one-cycle pulse after the last burst ends unattended
// ---------------------------------------------------------------------------
module alarm_beep_ctrl #(
    parameter int BEEPS        = 3,
    parameter int ON_TICKS     = 2,
    parameter int OFF_TICKS    = 2,
    parameter int PAUSE_TICKS  = 10,
    parameter int BURSTS       = 60,
    parameter int SNOOZE_TICKS = 3000,
    parameter int CW           = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic alarm_en,
    input  logic alarm_match,
    input  logic stop,
    input  logic snooze,
    output logic buzz,
    output logic active,
    output logic snoozing,
    output logic timeout
);

    localparam int BW = (BEEPS  > 1) ? $clog2(BEEPS)  : 1;
    localparam int RW = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    localparam logic [CW-1:0] ON_LD     = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_LD    = CW'(OFF_TICKS - 1);
    localparam logic [CW-1:0] PAUSE_LD  = CW'(PAUSE_TICKS - 1);
    localparam logic [CW-1:0] SNOOZE_LD = CW'(SNOOZE_TICKS - 1);
    localparam logic [BW-1:0] BEEP_LD   = BW'(BEEPS - 1);
    localparam logic [RW-1:0] BURST_LD  = RW'(BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_PAUSE,
        S_SNOOZE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tcnt_q,  tcnt_d;
    logic [BW-1:0] bcnt_q,  bcnt_d;
    logic [RW-1:0] rcnt_q,  rcnt_d;
    logic          timeout_q, timeout_d;

    // True when the current phase is still counting; a tick then only
    // decrements, so the counter can never wrap below zero.
    logic tcnt_nz;
    assign tcnt_nz = (tcnt_q != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            rcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            rcnt_q    <= rcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        rcnt_d    = rcnt_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A coincident stop wins over the match.
                if (!stop && alarm_en && alarm_match) begin
                    state_d = S_ON;
                    tcnt_d  = ON_LD;
                    bcnt_d  = BEEP_LD;
                    rcnt_d  = BURST_LD;
                end
            end

            S_ON, S_OFF, S_PAUSE: begin
                if (stop || !alarm_en) begin
                    state_d = S_IDLE;
                    tcnt_d  = '0;
                end else if (snooze) begin
                    // Snooze beats a phase end landing on the same cycle.
                    state_d = S_SNOOZE;
                    tcnt_d  = SNOOZE_LD;
                end else if (tick) begin
                    if (tcnt_nz) begin
                        tcnt_d = tcnt_q - CW'(1);
                    end else begin
                        case (state_q)
                            S_ON: begin
                                if (bcnt_q == '0) begin
                                    state_d = S_PAUSE;
                                    tcnt_d  = PAUSE_LD;
                                end else begin
                                    state_d = S_OFF;
                                    tcnt_d  = OFF_LD;
                                    bcnt_d  = bcnt_q - BW'(1);
                                end
                            end
                            S_OFF: begin
                                state_d = S_ON;
                                tcnt_d  = ON_LD;
                            end
                            S_PAUSE: begin
                                if (rcnt_q == '0) begin
                                    state_d   = S_IDLE;
                                    tcnt_d    = '0;
                                    timeout_d = 1'b1;
                                end else begin
                                    state_d = S_ON;
                                    tcnt_d  = ON_LD;
                                    bcnt_d  = BEEP_LD;
                                    rcnt_d  = rcnt_q - RW'(1);
                                end
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end

            S_SNOOZE: begin
                if (stop || !alarm_en) begin
                    state_d = S_IDLE;
                    tcnt_d  = '0;
                end else if (snooze) begin
                    // Repeated snooze extends the wait from now.
                    tcnt_d = SNOOZE_LD;
                end else if (tick) begin
                    if (tcnt_nz) begin
                        tcnt_d = tcnt_q - CW'(1);
                    end else begin
                        // Ringing resumes with a fresh timeout window.
                        state_d = S_ON;
                        tcnt_d  = ON_LD;
                        bcnt_d  = BEEP_LD;
                        rcnt_d  = BURST_LD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    assign buzz     = (state_q == S_ON);
    assign active   = (state_q == S_ON) || (state_q == S_OFF) || (state_q == S_PAUSE);
    assign snoozing = (state_q == S_SNOOZE);
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_alarm_beep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_beep_ctrl
//
// Directed bench for alarm_beep_ctrl. The DUT uses default timing parameters
// with BURSTS=2 and SNOOZE_TICKS=5 so that timeout and snooze are reached
// quickly. Ticks occur every 4 clocks. Outputs are sampled 1 time unit after
// the clock edge, as the packed vector {buzz, active, snoozing, timeout}.
//
// With defaults, the state after k ticks from the match within a burst is:
//   k%20 in 0..1 ON, 2..3 OFF, 4..5 ON, 6..7 OFF, 8..9 ON, 10..19 PAUSE.
// ---------------------------------------------------------------------------
module tb_alarm_beep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic alarm_en = 1'b0;
    logic alarm_match = 1'b0;
    logic stop = 1'b0;
    logic snooze = 1'b0;
    logic buzz, active, snoozing, timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    wire [3:0] outs = {buzz, active, snoozing, timeout};

    alarm_beep_ctrl #(
        .BEEPS(3), .ON_TICKS(2), .OFF_TICKS(2), .PAUSE_TICKS(10),
        .BURSTS(2), .SNOOZE_TICKS(5), .CW(12)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .alarm_en(alarm_en),
        .alarm_match(alarm_match), .stop(stop), .snooze(snooze),
        .buzz(buzz), .active(active), .snoozing(snoozing), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Three quiet clocks, then one tick clock; returns just after the tick edge.
    task automatic tick_once();
        step(); step(); step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        alarm_en = 1'b1;
        alarm_match = 1'b0; stop = 1'b0; snooze = 1'b0; tick = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic start_alarm();
        alarm_match = 1'b1;
        step();
        alarm_match = 1'b0;
    endtask

    function automatic logic [3:0] exp_ring(input int k);
        int p;
        p = k % 20;
        if (p < 10) return {((p / 2) % 2 == 0), 1'b1, 1'b0, 1'b0};
        return 4'b0100;
    endfunction

    task automatic test_reset();
        logic [3:0] e;
        do_reset();
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL reset_state: got %b expected %b", outs, 4'b0000);
        else pass_cnt++;
        // alarm_match while disarmed must not start ringing
        alarm_en = 1'b0;
        start_alarm();
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL match_disarmed: got %b expected %b", outs, 4'b0000);
        else pass_cnt++;
        // alarm_match together with stop stays idle
        alarm_en = 1'b1;
        alarm_match = 1'b1; stop = 1'b1;
        step();
        alarm_match = 1'b0; stop = 1'b0;
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL match_and_stop: got %b expected %b", outs, 4'b0000);
        else pass_cnt++;
        // reset mid-ON
        start_alarm();
        e = 4'b1100;
        total_cnt++;
        if (outs !== e) $display("FAIL ring_start: got %b expected %b", outs, e);
        else pass_cnt++;
        rst = 1'b0;
        step();
        rst = 1'b1;
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL reset_mid_on: got %b expected %b", outs, 4'b0000);
        else pass_cnt++;
        step();
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL reset_no_timeout: got %b expected %b", outs, 4'b0000);
        else pass_cnt++;
        // match coincident with tick: the tick is ignored, ON lasts 2 ticks
        alarm_match = 1'b1; tick = 1'b1;
        step();
        alarm_match = 1'b0; tick = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick_once();
            e = exp_ring(k);
            total_cnt++;
            if (outs !== e) $display("FAIL match_with_tick k=%0d: got %b expected %b", k, outs, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_pattern_timeout();
        logic [3:0] e;
        do_reset();
        start_alarm();
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick_once();
            e = exp_ring(k);
            total_cnt++;
            if (outs !== e) $display("FAIL pattern k=%0d: got %b expected %b", k, outs, e);
            else pass_cnt++;
        end
        tick_once();
        total_cnt++;
        if (outs !== 4'b0001) $display("FAIL timeout_pulse: got %b expected %b", outs, 4'b0001);
        else pass_cnt++;
        step();
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL timeout_one_cycle: got %b expected %b", outs, 4'b0000);
        else pass_cnt++;
    endtask

    task automatic test_snooze();
        logic [3:0] e;
        do_reset();
        start_alarm();
        for (int k = 1; k <= 4; k++) tick_once();
        total_cnt++;
        if (outs !== 4'b1100) $display("FAIL second_beep: got %b expected %b", outs, 4'b1100);
        else pass_cnt++;
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        for (int s = 0; s <= 4; s++) begin
            if (s > 0) tick_once();
            total_cnt++;
            if (outs !== 4'b0010) $display("FAIL snooze_wait s=%0d: got %b expected %b", s, outs, 4'b0010);
            else pass_cnt++;
        end
        tick_once();
        // fresh window: two full bursts before timeout
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick_once();
            e = exp_ring(k);
            total_cnt++;
            if (outs !== e) $display("FAIL after_snooze k=%0d: got %b expected %b", k, outs, e);
            else pass_cnt++;
        end
        tick_once();
        total_cnt++;
        if (outs !== 4'b0001) $display("FAIL snooze_timeout: got %b expected %b", outs, 4'b0001);
        else pass_cnt++;
    endtask

    task automatic test_stop_and_snooze();
        do_reset();
        start_alarm();
        for (int k = 1; k <= 12; k++) tick_once();
        total_cnt++;
        if (outs !== 4'b0100) $display("FAIL in_pause: got %b expected %b", outs, 4'b0100);
        else pass_cnt++;
        stop = 1'b1; snooze = 1'b1;
        step();
        stop = 1'b0; snooze = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick_once();
            total_cnt++;
            if (outs !== 4'b0000) $display("FAIL stop_snooze i=%0d: got %b expected %b", i, outs, 4'b0000);
            else pass_cnt++;
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        start_alarm();
        tick_once(); tick_once();
        total_cnt++;
        if (outs !== 4'b0100) $display("FAIL in_off: got %b expected %b", outs, 4'b0100);
        else pass_cnt++;
        alarm_en = 1'b0;
        step();
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL enable_drop: got %b expected %b", outs, 4'b0000);
        else pass_cnt++;
        alarm_en = 1'b1;
    endtask

    task automatic test_rematch();
        logic [3:0] e;
        do_reset();
        start_alarm();
        for (int k = 1; k < 20; k++) begin
            tick_once();
            // extra matches during the last ON tick and during PAUSE
            if (k == 1 || k == 12) start_alarm();
            e = exp_ring(k);
            total_cnt++;
            if (outs !== e) $display("FAIL rematch k=%0d: got %b expected %b", k, outs, e);
            else pass_cnt++;
        end
        tick_once();
        total_cnt++;
        if (outs !== 4'b1100) $display("FAIL rematch_burst2: got %b expected %b", outs, 4'b1100);
        else pass_cnt++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pattern_timeout();
        test_snooze();
        test_stop_and_snooze();
        test_enable_drop();
        test_rematch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alarm_beep_ctrl.md
Name: alarm_beep_ctrl

Overview:
- Alarm ringing sequencer for the digital clock's alarm path.
- Consumes the alarm-match strobe and a slow time-base tick, and drives the buzzer enable with a burst pattern: BEEPS beeps (ON/OFF), then a PAUSE of silence, repeated.
- Handles user stop, snooze re-arm and automatic timeout.
- Sits directly upstream of the buzzer driver and downstream of the time/alarm comparator.

Parameters:
- BEEPS, 3, beeps per burst (≥1)
- ON_TICKS, 2, ticks buzzer on per beep (≥1)
- OFF_TICKS, 2, ticks silent between beeps in a burst (≥1)
- PAUSE_TICKS, 10, ticks silent after each burst (≥1)
- BURSTS, 60, bursts before automatic timeout (≥1)
- SNOOZE_TICKS, 3000, ticks of silence after snooze (≥1)
- CW, 12, width of tick/snooze counter; must hold max(*_TICKS)-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst=0 resets on clk rising edge)
- tick  in  1  one-cycle time-base strobe (nominally 10 Hz)
- alarm_en  in  1  alarm armed level
- alarm_match  in  1  one-cycle strobe: current time equals alarm time
- stop  in  1  one-cycle strobe: user dismiss
- snooze  in  1  one-cycle strobe: user snooze
- buzz  out  1  buzzer enable
- active  out  1  ringing sequence in progress (ON/OFF/PAUSE)
- snoozing  out  1  in snooze wait
- timeout  out  1  one-cycle pulse when BURSTS completed without user action

Behaviour:
- Only clk edges update state. On rst=0: state=IDLE, all counters 0, all outputs 0.
- FSM states: IDLE, ON, OFF, PAUSE, SNOOZE. Moore decode from the state register, so outputs change in the same cycle as the state:
  - buzz=(ON)
  - active=(ON|OFF|PAUSE)
  - snoozing=(SNOOZE)
- timeout is a registered pulse asserted for exactly the cycle after the PAUSE→IDLE timeout transition.
- Counters:
  - tcnt (CW bits): phase tick counter.
  - bcnt: beeps remaining.
  - rcnt: bursts remaining.
  - On every phase entry tcnt loads (phase_TICKS-1).
  - In a phase, each tick with tcnt≠0 decrements tcnt; a tick with tcnt=0 ends the phase. Each phase therefore lasts exactly phase_TICKS ticks.
  - A tick in the same cycle as a load is ignored.
- Transition priority, highest first: rst > stop > !alarm_en > snooze > tick-driven.
- IDLE:
  - alarm_match & alarm_en → ON; load bcnt=BEEPS-1, rcnt=BURSTS-1.
  - Otherwise stay in IDLE.
- ON, end of phase:
  - bcnt=0 → PAUSE.
  - Else → OFF and bcnt--.
- OFF, end of phase → ON.
- PAUSE, end of phase:
  - rcnt=0 → IDLE and assert timeout.
  - Else → ON; rcnt--, bcnt=BEEPS-1.
- ON/OFF/PAUSE:
  - stop or !alarm_en → IDLE immediately (next edge).
  - snooze → SNOOZE; tcnt=SNOOZE_TICKS-1.
- SNOOZE:
  - stop or !alarm_en → IDLE.
  - Further snooze strobes reload tcnt=SNOOZE_TICKS-1 (extend).
  - End of phase → ON; bcnt=BEEPS-1, rcnt=BURSTS-1 (fresh timeout window).
- alarm_match outside IDLE is ignored; no restart and no counter reload.
- Simultaneous events:
  - stop & snooze in the same cycle → IDLE.
  - snooze & end of phase in the same cycle → SNOOZE.
  - alarm_match & stop in IDLE → stay in IDLE.
- Reset mid-sequence: next state is IDLE, buzz drops the cycle after the reset edge, and no timeout pulse is generated.
- Counters never wrap: decrement is gated by tcnt≠0.
- One full burst lasts BEEPS·ON + (BEEPS-1)·OFF + PAUSE ticks. With defaults: 6+4+10 = 20 ticks = 2 s.

Test Plan:
- Defaults, tick every 4 clocks, pulse alarm_en=1 & alarm_match → buzz high 2 ticks, low 2, high 2, low 2, high 2, low 10, then pattern repeats; active=1 throughout.
- BURSTS=2, no user input → exactly 2 bursts (40 ticks), then state IDLE, timeout high for 1 cycle, buzz/active=0.
- Snooze during 2nd beep with SNOOZE_TICKS=5 → buzz=0, snoozing=1 for 5 ticks, then a fresh burst of 3 beeps and a full BURSTS count before timeout.
- Stop asserted on the same cycle as snooze during PAUSE → IDLE next edge; snoozing never 1, no timeout pulse.
- alarm_en dropped mid-OFF → IDLE next edge. A second alarm_match while ringing produces no restart (beep count observed unchanged).
- rst=0 for one cycle while buzz=1, and alarm_match coincident with tick in IDLE → all outputs 0 after the reset edge. First ON phase after the match still lasts exactly ON_TICKS ticks.
